// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the hash-table FIFO read path.
// DEF_D_WIDTH must track the upstream FIFO word width.
package fifo_stream_reader_pkg;

  localparam int DEF_D_WIDTH = 8;

  // Ceiling log2 that can be used in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundles the upstream FIFO read port and the downstream valid/ready stream.
// master = the reader block, slave = the FIFO plus consumer side.
interface fifo_stream_reader_if #(
  parameter int D_WIDTH = fifo_stream_reader_pkg::DEF_D_WIDTH
);
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [D_WIDTH-1:0] fifo_dout;
  logic [D_WIDTH-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_stream_reader_rd_lat_pipe.sv
// Valid delay line matching the FIFO read latency: strobes capture when the
// popped word appears on fifo_dout and reports how many pops are outstanding.
module rd_lat_pipe
  import fifo_stream_reader_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int INF_W  = (clog2(RD_LAT + 1) > 0) ? clog2(RD_LAT + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  output logic             capture,
  output logic [INF_W-1:0] inflight
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT:0]   vld_pipe;

  assign vld_pipe = {vld_q, issue};

  // Shifts unconditionally: the FIFO latency is fixed, so no stall path exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[RD_LAT-1:0];
  end

  assign capture = vld_q[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + INF_W'(vld_q[i]);
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the hash-table FIFO: issues pops on credit, absorbs the
// read latency into a skid buffer and streams words out with full backpressure.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int D_WIDTH    = DEF_D_WIDTH,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_W      = 32,
  parameter int LVL_W      = clog2(SKID_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus,
  output logic [LVL_W-1:0]     level,
  output logic [CNT_W-1:0]     pop_count
);

  localparam int PTR_W = (clog2(SKID_DEPTH) > 0) ? clog2(SKID_DEPTH) : 1;
  localparam int INF_W = (clog2(RD_LAT + 1) > 0) ? clog2(RD_LAT + 1) : 1;
  localparam int SUM_W = clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  logic [D_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [INF_W-1:0]   inflight;
  logic               issue;
  logic               capture;
  logic               credit;
  logic               xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .INF_W  (INF_W)
  ) u_rd_lat_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .capture  (capture),
    .inflight (inflight)
  );

  // Credit counts words already in flight so a capture never meets a full
  // buffer; m_ready is deliberately kept out of this path.
  assign credit = (SUM_W'(inflight) + SUM_W'(level)) < SUM_W'(SKID_DEPTH);
  assign issue  = !rst && !bus.fifo_empty && credit;

  assign bus.fifo_rd_en = issue;
  assign bus.m_valid    = (level != '0);
  assign bus.m_data     = mem[rd_ptr];
  assign xfer           = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pop_count <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= bus.fifo_dout;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (xfer) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        pop_count <= pop_count + 1'b1;
      end
      case ({capture, xfer})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a RD_LAT=1 upstream FIFO model.
module tb_fifo_stream_reader;
  localparam int DW = 8, RD_LAT = 1, DEPTH = 4, CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.D_WIDTH(DW)) bus ();
  logic [2:0]    level;
  logic [CW-1:0] pop_count;

  fifo_stream_reader #(
    .D_WIDTH(DW), .RD_LAT(RD_LAT), .SKID_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .pop_count(pop_count)
  );

  // Upstream FIFO model: mode 0 normal, 1 forced empty, 2 forced non-empty.
  logic [7:0] fmem [4096];
  int         head = 0;
  int         tail = 0;
  int         mode = 2;
  logic [7:0] fdout;

  assign bus.fifo_empty = (mode == 2) ? 1'b0 : (mode == 1) ? 1'b1 : (head == tail);
  assign bus.fifo_dout  = fdout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= tail;
      fdout <= '0;
    end else if (bus.fifo_rd_en) begin
      fdout <= fmem[head[11:0]];
      head  <= head + 1;
    end
  end

  // Monitor: logs pops and beats, counts protocol violations.
  int         cyc = 0, got_n = 0, pop_n = 0, ne_n = 0, viol = 0;
  logic [7:0] got [4096];
  int         got_cyc [4096];
  int         pop_cyc [4096];
  logic       prev_pop = 1'b0, hold = 1'b0;
  logic [7:0] hold_d = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_pop <= 1'b0;
      hold     <= 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        pop_cyc[pop_n] <= cyc;
        pop_n          <= pop_n + 1;
      end
      if (!bus.fifo_empty) ne_n <= ne_n + 1;
      if (bus.m_valid && bus.m_ready) begin
        got[got_n]     <= bus.m_data;
        got_cyc[got_n] <= cyc;
        got_n          <= got_n + 1;
      end
      if (level > 3'(DEPTH)) viol <= viol + 1;
      if (prev_pop && level == 3'(DEPTH)) viol <= viol + 1;
      if (hold && (!bus.m_valid || bus.m_data !== hold_d)) viol <= viol + 1;
      hold     <= bus.m_valid && !bus.m_ready;
      hold_d   <= bus.m_data;
      prev_pop <= bus.fifo_rd_en;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[tail[11:0]] = v;
    tail = tail + 1;
  endtask

  task automatic wait_beats(input int base, input int n, input int budget, output bit to);
    int k;
    k = 0;
    while ((got_n - base) < n && k < budget) begin
      tick();
      k++;
    end
    to = ((got_n - base) < n);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en[%0d] got %b exp 0", i, bus.fifo_rd_en); else n_pass++;
      n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid[%0d] got %b exp 0", i, bus.m_valid); else n_pass++;
      n_chk++; if (level !== 3'd0) $display("FAIL reset_level[%0d] got %0d exp 0", i, level); else n_pass++;
      n_chk++; if (pop_count !== 32'd0) $display("FAIL reset_pop_count[%0d] got %0d exp 0", i, pop_count); else n_pass++;
    end
    n_chk++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data got %h exp 00", bus.m_data); else n_pass++;
    @(posedge clk);
    #1;
    mode = 0;
    rst  = 1'b0;
  endtask

  task automatic test_stream();
    int base, pb;
    bit to;
    base = got_n; pb = pop_n;
    for (int i = 1; i <= 16; i++) push(8'(i));
    bus.m_ready = 1'b1;
    wait_beats(base, 16, 80, to);
    n_chk++; if (to) $display("FAIL stream_timeout got %0d beats exp 16", got_n - base); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[base+i] !== 8'(i + 1)) $display("FAIL stream_beat[%0d] got %h exp %h", i, got[base+i], 8'(i + 1)); else n_pass++;
    end
    n_chk++; if (got_cyc[base] - pop_cyc[pb] != RD_LAT + 1) $display("FAIL stream_latency got %0d exp %0d", got_cyc[base] - pop_cyc[pb], RD_LAT + 1); else n_pass++;
    n_chk++; if (got_cyc[base+15] - got_cyc[base] != 15) $display("FAIL stream_gaps got span %0d exp 15", got_cyc[base+15] - got_cyc[base]); else n_pass++;
    tick(); tick();
    n_chk++; if (pop_count !== 32'd16) $display("FAIL stream_pop_count got %0d exp 16", pop_count); else n_pass++;
    n_chk++; if (level !== 3'd0) $display("FAIL stream_level_drained got %0d exp 0", level); else n_pass++;
  endtask

  task automatic test_backpressure();
    int base, pb;
    bit to;
    bus.m_ready = 1'b0;
    base = got_n; pb = pop_n;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (10) tick();
    n_chk++; if (pop_n - pb != 4) $display("FAIL bp_pops got %0d exp 4", pop_n - pb); else n_pass++;
    n_chk++; if (level !== 3'd4) $display("FAIL bp_level got %0d exp 4", level); else n_pass++;
    n_chk++; if (bus.m_data !== 8'h01) $display("FAIL bp_m_data got %h exp 01", bus.m_data); else n_pass++;
    n_chk++; if (bus.m_valid !== 1'b1) $display("FAIL bp_m_valid got %b exp 1", bus.m_valid); else n_pass++;
    bus.m_ready = 1'b1;
    wait_beats(base, 8, 40, to);
    n_chk++; if (to) $display("FAIL bp_timeout got %0d beats exp 8", got_n - base); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (got[base+i] !== 8'(i + 1)) $display("FAIL bp_beat[%0d] got %h exp %h", i, got[base+i], 8'(i + 1)); else n_pass++;
    end
    n_chk++; if (got_cyc[base+7] - got_cyc[base] != 7) $display("FAIL bp_gaps got span %0d exp 7", got_cyc[base+7] - got_cyc[base]); else n_pass++;
    tick(); tick();
    n_chk++; if (pop_count !== 32'd24) $display("FAIL bp_pop_count got %0d exp 24", pop_count); else n_pass++;
  endtask

  task automatic test_random_ready();
    int base, k, bad, first;
    logic [7:0] e;
    base = got_n;
    for (int i = 0; i < 1000; i++) push(8'(i * 37 + 11));
    k = 0;
    while ((got_n - base) < 1000 && k < 6000) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    n_chk++; if ((got_n - base) != 1000) $display("FAIL rand_count got %0d exp 1000", got_n - base); else n_pass++;
    bad = 0; first = -1;
    for (int i = 0; i < 1000; i++) begin
      e = 8'(i * 37 + 11);
      if (got[base+i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_chk++; if (bad != 0) $display("FAIL rand_data got %0d bad beats (first at %0d) exp 0", bad, first); else n_pass++;
    bus.m_ready = 1'b1;
    tick(); tick();
    n_chk++; if (pop_count !== 32'd1024) $display("FAIL rand_pop_count got %0d exp 1024", pop_count); else n_pass++;
    n_chk++; if (viol != 0) $display("FAIL rand_protocol got %0d violations exp 0", viol); else n_pass++;
  endtask

  task automatic test_sparse();
    int base, pb, nb, k;
    bus.m_ready = 1'b1;
    base = got_n; pb = pop_n; nb = ne_n;
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    k = 0;
    while ((got_n - base) < 8 && k < 60) begin
      mode = (k % 2 == 1) ? 1 : 0;
      tick();
      k++;
    end
    mode = 0;
    repeat (3) tick();
    n_chk++; if (pop_n - pb != 8) $display("FAIL sparse_pops got %0d exp 8", pop_n - pb); else n_pass++;
    n_chk++; if (pop_n - pb != ne_n - nb) $display("FAIL sparse_pop_per_nonempty got %0d exp %0d", pop_n - pb, ne_n - nb); else n_pass++;
    n_chk++; if (got_n - base != 8) $display("FAIL sparse_beats got %0d exp 8", got_n - base); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (got[base+i] !== 8'(8'h50 + i)) $display("FAIL sparse_beat[%0d] got %h exp %h", i, got[base+i], 8'(8'h50 + i)); else n_pass++;
    end
    n_chk++; if (pop_count !== 32'd1032) $display("FAIL sparse_pop_count got %0d exp 1032", pop_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'hF0 + i));
    tick(); tick();
    n_chk++; if (level !== 3'd1) $display("FAIL mid_pre_level got %0d exp 1", level); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL mid_rd_en got %b exp 0", bus.fifo_rd_en); else n_pass++;
    n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL mid_m_valid got %b exp 0", bus.m_valid); else n_pass++;
    n_chk++; if (level !== 3'd0) $display("FAIL mid_level got %0d exp 0", level); else n_pass++;
    n_chk++; if (pop_count !== 32'd0) $display("FAIL mid_pop_count got %0d exp 0", pop_count); else n_pass++;
    n_chk++; if (bus.m_data !== 8'h00) $display("FAIL mid_m_data got %h exp 00", bus.m_data); else n_pass++;
    tick(); tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    base = got_n;
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    wait_beats(base, 4, 30, to);
    repeat (5) tick();
    n_chk++; if (to || got_n - base != 4) $display("FAIL mid_beats got %0d exp 4", got_n - base); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (got[base+i] !== 8'(8'hA0 + i)) $display("FAIL mid_beat[%0d] got %h exp %h", i, got[base+i], 8'(8'hA0 + i)); else n_pass++;
    end
    n_chk++; if (pop_count !== 32'd4) $display("FAIL mid_pop_count_after got %0d exp 4", pop_count); else n_pass++;
    n_chk++; if (viol != 0) $display("FAIL final_protocol got %0d violations exp 0", viol); else n_pass++;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_sparse();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got %0d/%0d checks done", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
